ctrl_decode_stage: RTL and testbench
====================================

Name: ctrl_decode_stage

Overview:
- Registered, handshaked instruction-decode stage for the pipelined core. It replaces the purely combinational control decode.
- Decodes one 32-bit MIPS instruction per accepted transfer into the core control bundle (WTG, ALU, DM and mux selects) and holds it in an output register with valid/ready flow control.
- Adds a syscall-serialisation FSM, a flush input, illegal-instruction detection and optional per-class instruction counters.
- Sits between the fetch register and the execute stage.

Parameters:
- PC_W, 32, width of the pass-through PC.
- ALU_OP_W, `ALU_OP_BIT, width of op_alu.
- WTG_OP_W, `WTG_OP_BIT, width of op_wtg.
- DM_OP_W, `DM_OP_BIT, width of op_datamem.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  PC of the instruction.
- flush  in  1  kill the held instruction (taken branch/jump resolved downstream).
- out_valid  out  1  control bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  PC_W  registered PC.
- op_wtg  out  WTG_OP_W  next-PC operation.
- op_alu  out  ALU_OP_W  ALU operation.
- op_datamem  out  DM_OP_W  data-memory width/sign.
- w_en_regfile  out  1  register-file write enable.
- w_en_datamem  out  1  data-memory write enable.
- mux_regfile_req_w  out  `MUX_RF_REQW_BIT  write-register select.
- mux_regfile_data_w  out  `MUX_RF_DATAW_BIT  write-data select.
- mux_alu_data_y  out  `MUX_ALU_DATAY_BIT  ALU Y select.
- is_jump  out  1  jump instruction.
- is_branch  out  1  conditional branch.
- syscall_en  out  1  syscall instruction.
- illegal  out  1  opcode/funct not in decode table.
- syscall_busy  out  1  FSM waiting for syscall_ack.
- syscall_ack  in  1  syscall handler done, one-cycle pulse.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: out_valid=0, all control outputs 0, out_pc=0, FSM=RUN, counters=0. Control outputs stay registered when out_valid=0 but have no meaning then.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - Accept on in_valid && in_ready. The decoded bundle registers the next cycle, so latency is 1 cycle.
  - Hold: out_valid && !out_ready keeps every output stable.
  - A transfer completes on out_valid && out_ready. If no new accept occurs in the same cycle, out_valid clears.
- Decode table:
  - R-type shifts, add/addu/sub/subu/and/or/xor/nor/slt/sltu: w_en_regfile=1, req_w=RD, data_w=ALU, alu_y=RFB.
  - I-type ALU (addi, addiu, slti, sltiu): alu_y=EXTS.
  - andi/ori/xori: alu_y=EXTZ.
  - lui: ALU_OP_LUI, data_w=ALU, w_en_regfile=1.
  - Loads lb/lh/lw/lbu/lhu: op_alu=ADD, data_w=DM, DM op SB/SH/WD/UB/UH, w_en_regfile=1.
  - Stores sb/sh/sw: w_en_datamem=1, w_en_regfile=0.
  - Branches beq/bne/blez/bgtz/bltz(rt=0)/bgez(rt=1): matching WTG op, is_branch=1.
  - j: WTG_J26, is_jump=1.
  - jal: WTG_J26, is_jump=1, req_w=31, data_w=PC4, w_en_regfile=1.
  - jr: WTG_J32, is_jump=1.
  - syscall: syscall_en=1.
  - Any other encoding, including opcode 1 with rt∉{0,1}: illegal=1, with w_en_regfile, w_en_datamem, is_jump, is_branch and syscall_en all 0.
- FSM:
  - RUN -> SYSWAIT when a syscall is accepted. In SYSWAIT, in_ready=0 and syscall_busy=1.
  - SYSWAIT -> RUN on syscall_ack. The syscall bundle itself still drains normally.
  - syscall_ack while in RUN is ignored.
- Flush:
  - Clears out_valid next cycle and blocks accept in that cycle (in_ready forced 0).
  - Flush during SYSWAIT returns the FSM to RUN.
  - Flush has priority over out_ready and over a simultaneous syscall_ack.
- Reset mid-operation returns every register to its reset value, discarding a held bundle or a pending syscall.

Optional Feature:
- Macro: CTRL_DECODE_STATS_EN.
- When defined, adds outputs cnt_branch, cnt_jump, cnt_syscall and cnt_illegal, each CNT_W wide.
- Each counter increments on a completed output transfer of that class; flushed bundles are not counted.
- Counters wrap modulo 2^CNT_W and clear on rst.
- When not defined, these ports and their logic are absent.

Test Plan:
- addu r3,r1,r2 (0x00221821) with out_ready=1 -> next cycle out_valid=1, w_en_regfile=1, req_w=RD, alu_y=RFB, op_alu=ADD.
- Hold case: lw 0x8C220004 accepted, out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Then out_ready=1 -> transfer completes, data_w=DM, DM_OP_WD.
- Syscall 0x0000000C accepted -> syscall_busy=1 and in_ready=0 until syscall_ack. The cycle after the ack, in_ready=1.
- bgez 0x04210003 -> is_branch=1, op_wtg=WTG_OP_BGEZ. Then opcode 0x3F -> illegal=1, all write enables 0.
- flush asserted while a beq is held with out_ready=0 -> out_valid=0 next cycle. With stats enabled, cnt_branch stays 0.
- rst asserted in SYSWAIT with a held bundle -> next cycle out_valid=0, syscall_busy=0, counters=0.

Source files
------------

// File: rtl/ctrl_decode_stage_if.sv
// ---------------------------------------------------------------------------
// ctrl_decode_stage_if
// Purpose : handshake and control-bundle bus of the registered decode stage.
//           It carries the fetch-side transfer (in_*), the execute-side
//           transfer (out_* plus the decoded control bundle), and the flush
//           and syscall side-band signals.
// Modports: slave  - the decode stage (drives in_ready, out_*, control,
//                    syscall_busy)
//           master - the surrounding pipeline (drives in_*, flush,
//                    out_ready, syscall_ack)
// ---------------------------------------------------------------------------
`ifndef ALU_OP_BIT
`define ALU_OP_BIT 4
`endif
`ifndef WTG_OP_BIT
`define WTG_OP_BIT 4
`endif
`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`endif
`ifndef MUX_RF_REQW_BIT
`define MUX_RF_REQW_BIT 2
`endif
`ifndef MUX_RF_DATAW_BIT
`define MUX_RF_DATAW_BIT 2
`endif
`ifndef MUX_ALU_DATAY_BIT
`define MUX_ALU_DATAY_BIT 2
`endif

interface ctrl_decode_stage_if #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned ALU_OP_W = `ALU_OP_BIT,
  parameter int unsigned WTG_OP_W = `WTG_OP_BIT,
  parameter int unsigned DM_OP_W  = `DM_OP_BIT
);
  logic                          in_valid;
  logic                          in_ready;
  logic [31:0]                   in_instr;
  logic [PC_W-1:0]               in_pc;
  logic                          flush;
  logic                          out_valid;
  logic                          out_ready;
  logic [PC_W-1:0]               out_pc;
  logic [WTG_OP_W-1:0]           op_wtg;
  logic [ALU_OP_W-1:0]           op_alu;
  logic [DM_OP_W-1:0]            op_datamem;
  logic                          w_en_regfile;
  logic                          w_en_datamem;
  logic [`MUX_RF_REQW_BIT-1:0]   mux_regfile_req_w;
  logic [`MUX_RF_DATAW_BIT-1:0]  mux_regfile_data_w;
  logic [`MUX_ALU_DATAY_BIT-1:0] mux_alu_data_y;
  logic                          is_jump;
  logic                          is_branch;
  logic                          syscall_en;
  logic                          illegal;
  logic                          syscall_busy;
  logic                          syscall_ack;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready, syscall_ack,
    output in_ready, out_valid, out_pc, op_wtg, op_alu, op_datamem,
           w_en_regfile, w_en_datamem, mux_regfile_req_w, mux_regfile_data_w,
           mux_alu_data_y, is_jump, is_branch, syscall_en, illegal, syscall_busy
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready, syscall_ack,
    input  in_ready, out_valid, out_pc, op_wtg, op_alu, op_datamem,
           w_en_regfile, w_en_datamem, mux_regfile_req_w, mux_regfile_data_w,
           mux_alu_data_y, is_jump, is_branch, syscall_en, illegal, syscall_busy
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// ---------------------------------------------------------------------------
// ctrl_decode_stage
// Purpose : registered, valid/ready handshaked MIPS instruction decode.
//           Decodes one instruction per accepted transfer into the core
//           control bundle, holds it under back-pressure, serialises
//           syscalls (RUN/SYSWAIT FSM), supports flush and flags illegal
//           encodings.
// Ports   : clk, rst (synchronous, active-high)
//           bus  - ctrl_decode_stage_if.slave (fetch in_*, execute out_*,
//                  control bundle, flush, syscall_busy/syscall_ack)
//           cnt_branch/cnt_jump/cnt_syscall/cnt_illegal - completed-transfer
//                  counters, present only when CTRL_DECODE_STATS_EN is defined
// Encodings: ALU  ADD0 SUB1 AND2 OR3 XOR4 NOR5 SLT6 SLTU7 SLL8 SRL9 SRA10
//                 LUI11 SLLV12 SRLV13 SRAV14
//            WTG  PC4 0 J26 1 J32 2 BEQ3 BNE4 BLEZ5 BGTZ6 BLTZ7 BGEZ8
//            DM   WD0 SB1 SH2 UB3 UH4
//            req_w RT0 RD1 R31 2 | data_w ALU0 DM1 PC4 2 | alu_y RFB0 EXTS1 EXTZ2
// ---------------------------------------------------------------------------
`ifndef ALU_OP_BIT
`define ALU_OP_BIT 4
`endif
`ifndef WTG_OP_BIT
`define WTG_OP_BIT 4
`endif
`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`endif
`ifndef MUX_RF_REQW_BIT
`define MUX_RF_REQW_BIT 2
`endif
`ifndef MUX_RF_DATAW_BIT
`define MUX_RF_DATAW_BIT 2
`endif
`ifndef MUX_ALU_DATAY_BIT
`define MUX_ALU_DATAY_BIT 2
`endif

module ctrl_decode_stage #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned ALU_OP_W = `ALU_OP_BIT,
  parameter int unsigned WTG_OP_W = `WTG_OP_BIT,
  parameter int unsigned DM_OP_W  = `DM_OP_BIT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  ctrl_decode_stage_if.slave  bus
`ifdef CTRL_DECODE_STATS_EN
  ,
  output logic [CNT_W-1:0]    cnt_branch,
  output logic [CNT_W-1:0]    cnt_jump,
  output logic [CNT_W-1:0]    cnt_syscall,
  output logic [CNT_W-1:0]    cnt_illegal
`endif
);
  localparam int unsigned REQW_W = `MUX_RF_REQW_BIT;
  localparam int unsigned DATW_W = `MUX_RF_DATAW_BIT;
  localparam int unsigned ALUY_W = `MUX_ALU_DATAY_BIT;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(10);
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = ALU_OP_W'(11);
  localparam logic [ALU_OP_W-1:0] ALU_SLLV = ALU_OP_W'(12);
  localparam logic [ALU_OP_W-1:0] ALU_SRLV = ALU_OP_W'(13);
  localparam logic [ALU_OP_W-1:0] ALU_SRAV = ALU_OP_W'(14);

  localparam logic [WTG_OP_W-1:0] WTG_J26  = WTG_OP_W'(1);
  localparam logic [WTG_OP_W-1:0] WTG_J32  = WTG_OP_W'(2);
  localparam logic [WTG_OP_W-1:0] WTG_BEQ  = WTG_OP_W'(3);
  localparam logic [WTG_OP_W-1:0] WTG_BNE  = WTG_OP_W'(4);
  localparam logic [WTG_OP_W-1:0] WTG_BLEZ = WTG_OP_W'(5);
  localparam logic [WTG_OP_W-1:0] WTG_BGTZ = WTG_OP_W'(6);
  localparam logic [WTG_OP_W-1:0] WTG_BLTZ = WTG_OP_W'(7);
  localparam logic [WTG_OP_W-1:0] WTG_BGEZ = WTG_OP_W'(8);

  localparam logic [DM_OP_W-1:0] DM_WD = DM_OP_W'(0);
  localparam logic [DM_OP_W-1:0] DM_SB = DM_OP_W'(1);
  localparam logic [DM_OP_W-1:0] DM_SH = DM_OP_W'(2);
  localparam logic [DM_OP_W-1:0] DM_UB = DM_OP_W'(3);
  localparam logic [DM_OP_W-1:0] DM_UH = DM_OP_W'(4);

  localparam logic [REQW_W-1:0] REQW_RD  = REQW_W'(1);
  localparam logic [REQW_W-1:0] REQW_R31 = REQW_W'(2);
  localparam logic [DATW_W-1:0] DATW_DM  = DATW_W'(1);
  localparam logic [DATW_W-1:0] DATW_PC4 = DATW_W'(2);
  localparam logic [ALUY_W-1:0] ALUY_EXTS = ALUY_W'(1);
  localparam logic [ALUY_W-1:0] ALUY_EXTZ = ALUY_W'(2);

  typedef struct packed {
    logic [WTG_OP_W-1:0] wtg;
    logic [ALU_OP_W-1:0] alu;
    logic [DM_OP_W-1:0]  dm;
    logic                w_rf;
    logic                w_dm;
    logic [REQW_W-1:0]   req_w;
    logic [DATW_W-1:0]   data_w;
    logic [ALUY_W-1:0]   alu_y;
    logic                jump;
    logic                branch;
    logic                sys;
    logic                ill;
  } ctrl_t;

  typedef enum logic [0:0] {S_RUN, S_SYSWAIT} state_e;

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [PC_W-1:0] pc_q, pc_d;
  ctrl_t           dec_c;
  logic            in_ready_c, accept_c, fire_c;

  logic [5:0]  opc_c, fn_c;
  logic [4:0]  rt_c;
  logic [14:0] unused_instr;
  assign opc_c        = bus.in_instr[31:26];
  assign rt_c         = bus.in_instr[20:16];
  assign fn_c         = bus.in_instr[5:0];
  assign unused_instr = {bus.in_instr[25:21], bus.in_instr[15:6]};

  // Instruction decode table; anything unlisted is illegal with all enables 0.
  always_comb begin
    dec_c = '0;
    case (opc_c)
      6'h00: begin
        dec_c.w_rf  = 1'b1;
        dec_c.req_w = REQW_RD;
        case (fn_c)
          6'h00:        dec_c.alu = ALU_SLL;
          6'h02:        dec_c.alu = ALU_SRL;
          6'h03:        dec_c.alu = ALU_SRA;
          6'h04:        dec_c.alu = ALU_SLLV;
          6'h06:        dec_c.alu = ALU_SRLV;
          6'h07:        dec_c.alu = ALU_SRAV;
          6'h20, 6'h21: dec_c.alu = ALU_ADD;
          6'h22, 6'h23: dec_c.alu = ALU_SUB;
          6'h24:        dec_c.alu = ALU_AND;
          6'h25:        dec_c.alu = ALU_OR;
          6'h26:        dec_c.alu = ALU_XOR;
          6'h27:        dec_c.alu = ALU_NOR;
          6'h2A:        dec_c.alu = ALU_SLT;
          6'h2B:        dec_c.alu = ALU_SLTU;
          6'h08: begin
            dec_c      = '0;
            dec_c.jump = 1'b1;
            dec_c.wtg  = WTG_J32;
          end
          6'h0C: begin
            dec_c     = '0;
            dec_c.sys = 1'b1;
          end
          default: begin
            dec_c     = '0;
            dec_c.ill = 1'b1;
          end
        endcase
      end
      // REGIMM: only bltz (rt=0) and bgez (rt=1) exist in this core
      6'h01: begin
        case (rt_c)
          5'd0:    begin dec_c.branch = 1'b1; dec_c.wtg = WTG_BLTZ; end
          5'd1:    begin dec_c.branch = 1'b1; dec_c.wtg = WTG_BGEZ; end
          default: dec_c.ill = 1'b1;
        endcase
      end
      6'h02: begin dec_c.jump = 1'b1; dec_c.wtg = WTG_J26; end
      6'h03: begin
        dec_c.jump   = 1'b1;
        dec_c.wtg    = WTG_J26;
        dec_c.w_rf   = 1'b1;
        dec_c.req_w  = REQW_R31;
        dec_c.data_w = DATW_PC4;
      end
      6'h04: begin dec_c.branch = 1'b1; dec_c.wtg = WTG_BEQ;  end
      6'h05: begin dec_c.branch = 1'b1; dec_c.wtg = WTG_BNE;  end
      6'h06: begin dec_c.branch = 1'b1; dec_c.wtg = WTG_BLEZ; end
      6'h07: begin dec_c.branch = 1'b1; dec_c.wtg = WTG_BGTZ; end
      6'h08, 6'h09: begin dec_c.w_rf = 1'b1; dec_c.alu_y = ALUY_EXTS; dec_c.alu = ALU_ADD;  end
      6'h0A:        begin dec_c.w_rf = 1'b1; dec_c.alu_y = ALUY_EXTS; dec_c.alu = ALU_SLT;  end
      6'h0B:        begin dec_c.w_rf = 1'b1; dec_c.alu_y = ALUY_EXTS; dec_c.alu = ALU_SLTU; end
      6'h0C:        begin dec_c.w_rf = 1'b1; dec_c.alu_y = ALUY_EXTZ; dec_c.alu = ALU_AND;  end
      6'h0D:        begin dec_c.w_rf = 1'b1; dec_c.alu_y = ALUY_EXTZ; dec_c.alu = ALU_OR;   end
      6'h0E:        begin dec_c.w_rf = 1'b1; dec_c.alu_y = ALUY_EXTZ; dec_c.alu = ALU_XOR;  end
      6'h0F:        begin dec_c.w_rf = 1'b1; dec_c.alu_y = ALUY_EXTZ; dec_c.alu = ALU_LUI;  end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec_c.w_rf   = 1'b1;
        dec_c.data_w = DATW_DM;
        dec_c.alu_y  = ALUY_EXTS;
        case (opc_c)
          6'h20:   dec_c.dm = DM_SB;
          6'h21:   dec_c.dm = DM_SH;
          6'h24:   dec_c.dm = DM_UB;
          6'h25:   dec_c.dm = DM_UH;
          default: dec_c.dm = DM_WD;
        endcase
      end
      6'h28, 6'h29, 6'h2B: begin
        dec_c.w_dm  = 1'b1;
        dec_c.alu_y = ALUY_EXTS;
        case (opc_c)
          6'h28:   dec_c.dm = DM_SB;
          6'h29:   dec_c.dm = DM_SH;
          default: dec_c.dm = DM_WD;
        endcase
      end
      default: dec_c.ill = 1'b1;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
    end
  end

  // Handshake, flush priority and syscall-serialisation next state
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    in_ready_c = (state_q == S_RUN) && (!valid_q || bus.out_ready) && !bus.flush;
    accept_c   = bus.in_valid && in_ready_c;
    fire_c     = valid_q && bus.out_ready && !bus.flush;

    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept_c) begin
      valid_d = 1'b1;
      ctrl_d  = dec_c;
      pc_d    = bus.in_pc;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_RUN:     if (accept_c && dec_c.sys) state_d = S_SYSWAIT;
      S_SYSWAIT: if (bus.flush || bus.syscall_ack) state_d = S_RUN;
      default:   state_d = S_RUN;
    endcase
  end

  assign bus.in_ready           = in_ready_c;
  assign bus.out_valid          = valid_q;
  assign bus.out_pc             = pc_q;
  assign bus.op_wtg             = ctrl_q.wtg;
  assign bus.op_alu             = ctrl_q.alu;
  assign bus.op_datamem         = ctrl_q.dm;
  assign bus.w_en_regfile       = ctrl_q.w_rf;
  assign bus.w_en_datamem       = ctrl_q.w_dm;
  assign bus.mux_regfile_req_w  = ctrl_q.req_w;
  assign bus.mux_regfile_data_w = ctrl_q.data_w;
  assign bus.mux_alu_data_y     = ctrl_q.alu_y;
  assign bus.is_jump            = ctrl_q.jump;
  assign bus.is_branch          = ctrl_q.branch;
  assign bus.syscall_en         = ctrl_q.sys;
  assign bus.illegal            = ctrl_q.ill;
  assign bus.syscall_busy       = (state_q == S_SYSWAIT);

`ifdef CTRL_DECODE_STATS_EN
  logic [CNT_W-1:0] cnt_branch_q, cnt_jump_q, cnt_syscall_q, cnt_illegal_q;

  // Per-class counters of completed (non-flushed) output transfers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_branch_q  <= '0;
      cnt_jump_q    <= '0;
      cnt_syscall_q <= '0;
      cnt_illegal_q <= '0;
    end else if (fire_c) begin
      if (ctrl_q.branch) cnt_branch_q  <= cnt_branch_q  + CNT_W'(1);
      if (ctrl_q.jump)   cnt_jump_q    <= cnt_jump_q    + CNT_W'(1);
      if (ctrl_q.sys)    cnt_syscall_q <= cnt_syscall_q + CNT_W'(1);
      if (ctrl_q.ill)    cnt_illegal_q <= cnt_illegal_q + CNT_W'(1);
    end
  end

  assign cnt_branch  = cnt_branch_q;
  assign cnt_jump    = cnt_jump_q;
  assign cnt_syscall = cnt_syscall_q;
  assign cnt_illegal = cnt_illegal_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  logic             unused_fire;
  assign unused_cnt_w = '0;
  assign unused_fire  = fire_c;
`endif
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_ctrl_decode_stage
// Directed-vector bench with a transaction-level model of the decode stage:
// instructions are classified into classes and the control bundle is built
// from the class; flow control is tracked as "held bundle + syscall pending".
// The model is compared against the DUT on every falling edge, and literal
// hand-computed expectations pin key points of each scenario.
// ---------------------------------------------------------------------------
module tb_ctrl_decode_stage;
  localparam int unsigned PC_W = 32;

  // Encodings the stage is built with
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
  localparam logic [3:0] A_NOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7, A_SLL = 4'd8, A_SRL = 4'd9;
  localparam logic [3:0] A_SRA = 4'd10, A_LUI = 4'd11, A_SLLV = 4'd12, A_SRLV = 4'd13, A_SRAV = 4'd14;
  localparam logic [3:0] W_PC4 = 4'd0, W_J26 = 4'd1, W_J32 = 4'd2, W_BEQ = 4'd3, W_BNE = 4'd4;
  localparam logic [3:0] W_BLEZ = 4'd5, W_BGTZ = 4'd6, W_BLTZ = 4'd7, W_BGEZ = 4'd8;
  localparam logic [2:0] D_WD = 3'd0, D_SB = 3'd1, D_SH = 3'd2, D_UB = 3'd3, D_UH = 3'd4;
  localparam logic [1:0] RQ_RT = 2'd0, RQ_RD = 2'd1, RQ_31 = 2'd2;
  localparam logic [1:0] DW_ALU = 2'd0, DW_DM = 2'd1, DW_PC4 = 2'd2;
  localparam logic [1:0] Y_RFB = 2'd0, Y_EXTS = 2'd1, Y_EXTZ = 2'd2;

  typedef struct packed {
    logic [3:0] wtg; logic [3:0] alu; logic [2:0] dm;
    logic wrf; logic wdm; logic [1:0] reqw; logic [1:0] dataw; logic [1:0] aluy;
    logic jmp; logic br; logic sys; logic ill;
  } bun_t;

  typedef enum {C_ILL, C_RALU, C_IMMS, C_IMMZ, C_LUI, C_LOAD, C_STORE,
                C_BR, C_J, C_JAL, C_JR, C_SYS} cls_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_decode_stage_if #(.PC_W(PC_W)) bus_if ();

`ifdef CTRL_DECODE_STATS_EN
  logic [31:0] cnt_branch, cnt_jump, cnt_syscall, cnt_illegal;
`endif

  ctrl_decode_stage #(.PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef CTRL_DECODE_STATS_EN
    ,
    .cnt_branch  (cnt_branch),
    .cnt_jump    (cnt_jump),
    .cnt_syscall (cnt_syscall),
    .cnt_illegal (cnt_illegal)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [4:0] rtype_alu(input logic [5:0] fn);
    // {known, op}
    case (fn)
      6'h00: return {1'b1, A_SLL};   6'h02: return {1'b1, A_SRL};
      6'h03: return {1'b1, A_SRA};   6'h04: return {1'b1, A_SLLV};
      6'h06: return {1'b1, A_SRLV};  6'h07: return {1'b1, A_SRAV};
      6'h20: return {1'b1, A_ADD};   6'h21: return {1'b1, A_ADD};
      6'h22: return {1'b1, A_SUB};   6'h23: return {1'b1, A_SUB};
      6'h24: return {1'b1, A_AND};   6'h25: return {1'b1, A_OR};
      6'h26: return {1'b1, A_XOR};   6'h27: return {1'b1, A_NOR};
      6'h2A: return {1'b1, A_SLT};   6'h2B: return {1'b1, A_SLTU};
      default: return 5'b0;
    endcase
  endfunction

  function automatic cls_e classify(input logic [31:0] w);
    logic [5:0] op;
    logic [4:0] tmp;
    op = w[31:26];
    if (op == 6'h00) begin
      tmp = rtype_alu(w[5:0]);
      if (w[5:0] == 6'h08) return C_JR;
      if (w[5:0] == 6'h0C) return C_SYS;
      return tmp[4] ? C_RALU : C_ILL;
    end
    if (op == 6'h01) return (w[20:16] <= 5'd1) ? C_BR : C_ILL;
    if (op == 6'h02) return C_J;
    if (op == 6'h03) return C_JAL;
    if (op >= 6'h04 && op <= 6'h07) return C_BR;
    if (op >= 6'h08 && op <= 6'h0B) return C_IMMS;
    if (op >= 6'h0C && op <= 6'h0E) return C_IMMZ;
    if (op == 6'h0F) return C_LUI;
    if (op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25) return C_LOAD;
    if (op == 6'h28 || op == 6'h29 || op == 6'h2B) return C_STORE;
    return C_ILL;
  endfunction

  // Access width from the opcode: low bits 00 byte, 01 half, 11 word; bit2 unsigned
  function automatic logic [2:0] mem_op(input logic [5:0] op);
    if (op[1:0] == 2'b11) return D_WD;
    if (op[2]) return op[0] ? D_UH : D_UB;
    return op[0] ? D_SH : D_SB;
  endfunction

  function automatic bun_t model_decode(input logic [31:0] w);
    bun_t b;
    logic [5:0] op;
    logic [4:0] ra;
    logic [3:0] br_ops [8];
    b  = '0;
    op = w[31:26];
    br_ops = '{W_PC4, W_BGEZ, W_PC4, W_PC4, W_BEQ, W_BNE, W_BLEZ, W_BGTZ};
    case (classify(w))
      C_RALU: begin ra = rtype_alu(w[5:0]); b.alu = ra[3:0]; b.wrf = 1; b.reqw = RQ_RD; end
      C_IMMS: begin
        b.wrf = 1; b.aluy = Y_EXTS;
        b.alu = (op == 6'h0A) ? A_SLT : (op == 6'h0B) ? A_SLTU : A_ADD;
      end
      C_IMMZ: begin
        b.wrf = 1; b.aluy = Y_EXTZ;
        b.alu = (op == 6'h0C) ? A_AND : (op == 6'h0D) ? A_OR : A_XOR;
      end
      C_LUI:   begin b.wrf = 1; b.aluy = Y_EXTZ; b.alu = A_LUI; end
      C_LOAD:  begin b.wrf = 1; b.aluy = Y_EXTS; b.dataw = DW_DM; b.dm = mem_op(op); end
      C_STORE: begin b.wdm = 1; b.aluy = Y_EXTS; b.dm = mem_op(op); end
      C_BR: begin
        b.br = 1;
        if (op == 6'h01) b.wtg = (w[16]) ? W_BGEZ : W_BLTZ;
        else b.wtg = br_ops[op[2:0]];
      end
      C_J:   begin b.jmp = 1; b.wtg = W_J26; end
      C_JAL: begin b.jmp = 1; b.wtg = W_J26; b.wrf = 1; b.reqw = RQ_31; b.dataw = DW_PC4; end
      C_JR:  begin b.jmp = 1; b.wtg = W_J32; end
      C_SYS: b.sys = 1;
      default: b.ill = 1;
    endcase
    return b;
  endfunction

  bit          m_live = 0;
  bit          m_valid, m_busy;
  bun_t        m_bun;
  logic [31:0] m_pc;
  int unsigned m_cb, m_cj, m_cs, m_ci;

  function automatic bit exp_in_ready();
    return !m_busy && (!m_valid || bus_if.out_ready) && !bus_if.flush;
  endfunction

  always @(posedge clk) begin
    bit   acc;
    bun_t nb;
    acc = bus_if.in_valid && exp_in_ready();
    nb  = model_decode(bus_if.in_instr);
    if (rst) begin
      m_live = 1; m_valid = 0; m_busy = 0; m_bun = '0; m_pc = '0;
      m_cb = 0; m_cj = 0; m_cs = 0; m_ci = 0;
    end else if (m_live) begin
      if (m_valid && bus_if.out_ready && !bus_if.flush) begin
        m_cb += m_bun.br; m_cj += m_bun.jmp; m_cs += m_bun.sys; m_ci += m_bun.ill;
      end
      if (m_busy) begin
        if (bus_if.flush || bus_if.syscall_ack) m_busy = 0;
      end else if (acc && nb.sys) begin
        m_busy = 1;
      end
      if (bus_if.flush) m_valid = 0;
      else if (acc) begin m_valid = 1; m_bun = nb; m_pc = bus_if.in_pc; end
      else if (bus_if.out_ready) m_valid = 0;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (m_live) begin
      chk("out_valid", bus_if.out_valid, m_valid);
      chk("in_ready", bus_if.in_ready, exp_in_ready());
      chk("syscall_busy", bus_if.syscall_busy, m_busy);
      if (m_valid) begin
        chk("out_pc", bus_if.out_pc, m_pc);
        chk("op_wtg", bus_if.op_wtg, m_bun.wtg);
        chk("op_alu", bus_if.op_alu, m_bun.alu);
        chk("op_datamem", bus_if.op_datamem, m_bun.dm);
        chk("w_en_regfile", bus_if.w_en_regfile, m_bun.wrf);
        chk("w_en_datamem", bus_if.w_en_datamem, m_bun.wdm);
        chk("req_w", bus_if.mux_regfile_req_w, m_bun.reqw);
        chk("data_w", bus_if.mux_regfile_data_w, m_bun.dataw);
        chk("alu_y", bus_if.mux_alu_data_y, m_bun.aluy);
        chk("is_jump", bus_if.is_jump, m_bun.jmp);
        chk("is_branch", bus_if.is_branch, m_bun.br);
        chk("syscall_en", bus_if.syscall_en, m_bun.sys);
        chk("illegal", bus_if.illegal, m_bun.ill);
      end
`ifdef CTRL_DECODE_STATS_EN
      chk("cnt_branch", cnt_branch, m_cb);
      chk("cnt_jump", cnt_jump, m_cj);
      chk("cnt_syscall", cnt_syscall, m_cs);
      chk("cnt_illegal", cnt_illegal, m_ci);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] w, input logic [31:0] pc);
    bus_if.in_valid = 1'b1;
    bus_if.in_instr = w;
    bus_if.in_pc    = pc;
  endtask

  logic [31:0] prog [12];

  initial begin
    prog = '{32'h08000010, 32'h0C000010, 32'h03E00008, 32'hAC220008,
             32'h90220000, 32'h3C011234, 32'h34210001, 32'h00021080,
             32'h0022182A, 32'h00431004, 32'h2C220007, 32'h94220002};
    bus_if.in_valid    = 1'b0;
    bus_if.in_instr    = '0;
    bus_if.in_pc       = '0;
    bus_if.flush       = 1'b0;
    bus_if.out_ready   = 1'b0;
    bus_if.syscall_ack = 1'b0;
    cyc(); cyc();
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_out_pc", bus_if.out_pc, 0);
    chk("rst_op_alu", bus_if.op_alu, 0);
    chk("rst_busy", bus_if.syscall_busy, 0);
    chk("rst_in_ready", bus_if.in_ready, 1);
    rst = 1'b0;

    // addu r3,r1,r2
    bus_if.out_ready = 1'b1;
    present(32'h00221821, 32'h100);
    cyc();
    bus_if.in_valid = 1'b0;
    chk("addu_valid", bus_if.out_valid, 1);
    chk("addu_wrf", bus_if.w_en_regfile, 1);
    chk("addu_reqw", bus_if.mux_regfile_req_w, RQ_RD);
    chk("addu_aluy", bus_if.mux_alu_data_y, Y_RFB);
    chk("addu_alu", bus_if.op_alu, A_ADD);
    chk("addu_pc", bus_if.out_pc, 32'h100);
    cyc();
    chk("addu_drained", bus_if.out_valid, 0);

    // lw held for 3 cycles with addi waiting upstream
    bus_if.out_ready = 1'b0;
    present(32'h8C220004, 32'h104);
    cyc();
    present(32'h20430005, 32'h108);
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", bus_if.out_valid, 1);
      chk("hold_in_ready", bus_if.in_ready, 0);
      chk("hold_dataw", bus_if.mux_regfile_data_w, DW_DM);
      chk("hold_dm", bus_if.op_datamem, D_WD);
      chk("hold_pc", bus_if.out_pc, 32'h104);
      cyc();
    end
    bus_if.out_ready = 1'b1;
    cyc();
    bus_if.in_valid = 1'b0;
    chk("addi_pc", bus_if.out_pc, 32'h108);
    chk("addi_aluy", bus_if.mux_alu_data_y, Y_EXTS);
    chk("addi_reqw", bus_if.mux_regfile_req_w, RQ_RT);
    cyc();

    // syscall serialisation
    present(32'h0000000C, 32'h200);
    cyc();
    present(32'h00221821, 32'h204);
    chk("sys_busy", bus_if.syscall_busy, 1);
    chk("sys_in_ready", bus_if.in_ready, 0);
    chk("sys_en", bus_if.syscall_en, 1);
    cyc();
    chk("sys_drained", bus_if.out_valid, 0);
    chk("sys_still_busy", bus_if.syscall_busy, 1);
    chk("sys_still_blocked", bus_if.in_ready, 0);
    bus_if.syscall_ack = 1'b1;
    cyc();
    bus_if.syscall_ack = 1'b0;
    chk("ack_busy", bus_if.syscall_busy, 0);
    chk("ack_in_ready", bus_if.in_ready, 1);
    cyc();
    bus_if.in_valid = 1'b0;
    chk("post_sys_pc", bus_if.out_pc, 32'h204);
    cyc();
    bus_if.syscall_ack = 1'b1;
    cyc();
    bus_if.syscall_ack = 1'b0;
    chk("ack_in_run", bus_if.syscall_busy, 0);

    // bgez, undefined opcode, REGIMM rt=2
    present(32'h04210003, 32'h300);
    cyc();
    present(32'hFC000000, 32'h304);
    chk("bgez_br", bus_if.is_branch, 1);
    chk("bgez_wtg", bus_if.op_wtg, W_BGEZ);
    cyc();
    present(32'h04420001, 32'h308);
    chk("ill_flag", bus_if.illegal, 1);
    chk("ill_wrf", bus_if.w_en_regfile, 0);
    chk("ill_wdm", bus_if.w_en_datamem, 0);
    chk("ill_br", bus_if.is_branch, 0);
    cyc();
    bus_if.in_valid = 1'b0;
    chk("regimm_ill", bus_if.illegal, 1);
    chk("regimm_br", bus_if.is_branch, 0);
    cyc();

    // flush a held beq, together with out_ready
    bus_if.out_ready = 1'b0;
    present(32'h10220002, 32'h310);
    cyc();
    present(32'h00221821, 32'h314);
    chk("beq_wtg", bus_if.op_wtg, W_BEQ);
    bus_if.flush     = 1'b1;
    bus_if.out_ready = 1'b1;
    #1;
    chk("flush_in_ready", bus_if.in_ready, 0);
    cyc();
    bus_if.flush    = 1'b0;
    bus_if.in_valid = 1'b0;
    chk("flush_valid", bus_if.out_valid, 0);
`ifdef CTRL_DECODE_STATS_EN
    chk("flush_cnt_br", cnt_branch, 1);
`endif
    cyc();

    // flush and ack together while waiting on a syscall
    bus_if.out_ready = 1'b0;
    present(32'h0000000C, 32'h320);
    cyc();
    bus_if.in_valid = 1'b0;
    chk("sys2_busy", bus_if.syscall_busy, 1);
    bus_if.flush       = 1'b1;
    bus_if.syscall_ack = 1'b1;
    cyc();
    bus_if.flush       = 1'b0;
    bus_if.syscall_ack = 1'b0;
    chk("sys2_flush_busy", bus_if.syscall_busy, 0);
    chk("sys2_flush_valid", bus_if.out_valid, 0);
`ifdef CTRL_DECODE_STATS_EN
    chk("sys2_cnt_sys", cnt_syscall, 1);
`endif

    // streaming program, then with alternating back-pressure
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      present(prog[i], 32'h400 + 32'(4 * i));
      cyc();
    end
    bus_if.in_valid = 1'b0;
    cyc();
`ifdef CTRL_DECODE_STATS_EN
    chk("stream_cnt_jump", cnt_jump, 3);
`endif
    for (int i = 0; i < 12; i++) begin
      present(prog[11 - i], 32'h500 + 32'(4 * i));
      bus_if.out_ready = (i % 3) != 1;
      cyc();
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    cyc(); cyc();

    // reset while a syscall bundle is held and the FSM waits
    bus_if.out_ready = 1'b0;
    present(32'h0000000C, 32'h600);
    cyc();
    bus_if.in_valid = 1'b0;
    chk("pre_rst_busy", bus_if.syscall_busy, 1);
    chk("pre_rst_valid", bus_if.out_valid, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_valid", bus_if.out_valid, 0);
    chk("rst2_busy", bus_if.syscall_busy, 0);
    chk("rst2_in_ready", bus_if.in_ready, 1);
`ifdef CTRL_DECODE_STATS_EN
    chk("rst2_cnt_jump", cnt_jump, 0);
    chk("rst2_cnt_ill", cnt_illegal, 0);
`endif
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
